// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and widths for the hazard/forwarding unit: pipeline tracker entry,
// register-number width and counter width.
package hazard_forward_unit_pkg;

    localparam int unsigned REGISTERWIDTH = 5;
    localparam int unsigned COUNTERWIDTH  = 32;

    typedef struct packed {
        logic                     valid;
        logic [REGISTERWIDTH-1:0] rd;
        logic                     regWrite;
        logic                     isLoad;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

endpackage

// File: rtl/hazard_compare.sv
// Compares one source register against one tracker entry; r0 never matches.
module hazard_compare
    import hazard_forward_unit_pkg::*;
(
    input  logic [REGISTERWIDTH-1:0] src_i,
    input  stage_entry_t             entry_i,
    output logic                     match_o
);

    always_comb begin
        match_o = entry_i.valid && entry_i.regWrite &&
                  (entry_i.rd == src_i) && (src_i != '0);
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding unit for a 5-stage pipeline.
// Define FORWARDING_EN to enable EX/MEM/WB forwarding; otherwise EX/MEM hazards stall.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     idValid,
    input  logic [REGISTERWIDTH-1:0] idRs,
    input  logic [REGISTERWIDTH-1:0] idRt,
    input  logic                     idUsesRt,
    input  logic [REGISTERWIDTH-1:0] idRd,
    input  logic                     idRegWrite,
    input  logic                     idIsLoad,
    input  logic                     flush,
    output logic                     forward1,
    output logic                     forward2,
    output logic                     memForward1,
    output logic                     memForward2,
    output logic                     wbForward1,
    output logic                     wbForward2,
    output logic                     stall,
    output logic [COUNTERWIDTH-1:0]  stalls,
    output logic [COUNTERWIDTH-1:0]  dataHazards
);

    stage_entry_t            ex_q, mem_q, wb_q, ex_d;
    stage_entry_t            stage [3];
    logic                    counted_q, counted_d;
    logic [COUNTERWIDTH-1:0] stalls_q, stalls_d;
    logic [COUNTERWIDTH-1:0] hazards_q, hazards_d;
    logic [2:0]              rsHit, rtHitRaw, rtHit;
    logic                    active, anyMatch;

    assign stage[0] = ex_q;
    assign stage[1] = mem_q;
    assign stage[2] = wb_q;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    for (genvar g = 0; g < 3; g++) begin : g_cmp
        hazard_compare u_rs (.src_i(idRs), .entry_i(stage[g]), .match_o(rsHit[g]));
        hazard_compare u_rt (.src_i(idRt), .entry_i(stage[g]), .match_o(rtHitRaw[g]));
    end

    assign rtHit  = rtHitRaw & {3{idUsesRt}};
    assign active = idValid && !flush && !reset;

    always_comb begin
        forward1    = 1'b0;
        forward2    = 1'b0;
        memForward1 = 1'b0;
        memForward2 = 1'b0;
        wbForward1  = 1'b0;
        wbForward2  = 1'b0;
        stall       = 1'b0;
        if (active) begin
`ifdef FORWARDING_EN
            // A load in EX has no result yet: stall instead of forwarding from EX.
            stall       = ex_q.isLoad && (rsHit[0] || rtHit[0]);
            forward1    = rsHit[0] && !ex_q.isLoad;
            memForward1 = !rsHit[0] && rsHit[1];
            wbForward1  = !rsHit[0] && !rsHit[1] && rsHit[2];
            forward2    = rtHit[0] && !ex_q.isLoad;
            memForward2 = !rtHit[0] && rtHit[1];
            wbForward2  = !rtHit[0] && !rtHit[1] && rtHit[2];
`else
            // Register file writes before it reads, so WB matches are harmless.
            stall = |{rsHit[1:0], rtHit[1:0]};
`endif
        end
    end

    always_comb begin
        ex_d = BUBBLE;
        if (idValid && !flush && !stall) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = idRd;
            ex_d.regWrite = idRegWrite;
            ex_d.isLoad   = idIsLoad;
        end
        anyMatch  = active && ((|rsHit) || (|rtHit));
        stalls_d  = stalls_q + COUNTERWIDTH'(stall);
        hazards_d = hazards_q + COUNTERWIDTH'(anyMatch && !counted_q);
        // Held instruction stays counted only while it keeps stalling.
        counted_d = stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= BUBBLE;
            mem_q     <= BUBBLE;
            wb_q      <= BUBBLE;
            counted_q <= 1'b0;
            stalls_q  <= '0;
            hazards_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            counted_q <= counted_d;
            stalls_q  <= stalls_d;
            hazards_q <= hazards_d;
        end
    end

    assign stalls      = stalls_q;
    assign dataHazards = hazards_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit; follows FORWARDING_EN like the design.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        idValid = 1'b0;
    logic [4:0]  idRs = '0, idRt = '0, idRd = '0;
    logic        idUsesRt = 1'b0, idRegWrite = 1'b0, idIsLoad = 1'b0, flush = 1'b0;
    logic        forward1, forward2, memForward1, memForward2, wbForward1, wbForward2, stall;
    logic [31:0] stalls, dataHazards;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .idRd(idRd), .idRegWrite(idRegWrite), .idIsLoad(idIsLoad),
        .flush(flush), .forward1(forward1), .forward2(forward2),
        .memForward1(memForward1), .memForward2(memForward2),
        .wbForward1(wbForward1), .wbForward2(wbForward2), .stall(stall),
        .stalls(stalls), .dataHazards(dataHazards)
    );

    int total = 0;
    int bad = 0;

    // Flags packed as {fwd1, fwd2, mem1, mem2, wb1, wb2, stall}.
    logic [6:0]  fexp_q[$], fobs_q[$];
    logic [31:0] sexp_q[$], sobs_q[$], hexp_q[$], hobs_q[$];

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
    logic        m_v[3], m_w[3], m_ld[3];
    logic [4:0]  m_rd[3];
    logic        m_counted;
    logic [31:0] m_stalls, m_haz;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic cyc(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fl, output logic exp_stall);
        logic [6:0] f;
        logic       act, anyh;
        logic       h1[3], h2[3];
        @(negedge clk);
        reset = rst; idValid = v; idRs = rs; idRt = rt; idUsesRt = ut;
        idRd = rd; idRegWrite = rw; idIsLoad = ld; flush = fl;
        act  = v && !fl && !rst;
        anyh = 1'b0;
        f    = '0;
        for (int s = 0; s < 3; s++) begin
            h1[s] = m_v[s] && m_w[s] && (m_rd[s] == rs) && (rs != 5'd0);
            h2[s] = ut && m_v[s] && m_w[s] && (m_rd[s] == rt) && (rt != 5'd0);
            anyh  = anyh || h1[s] || h2[s];
        end
        if (act) begin
            if (FWD) begin
                if (h1[0]) begin
                    if (m_ld[0]) f[0] = 1'b1; else f[6] = 1'b1;
                end else if (h1[1]) f[4] = 1'b1;
                else if (h1[2]) f[2] = 1'b1;
                if (h2[0]) begin
                    if (m_ld[0]) f[0] = 1'b1; else f[5] = 1'b1;
                end else if (h2[1]) f[3] = 1'b1;
                else if (h2[2]) f[1] = 1'b1;
            end else begin
                f[0] = h1[0] || h1[1] || h2[0] || h2[1];
            end
        end
        exp_stall = f[0];
        fexp_q.push_back(f);
        #1;
        fobs_q.push_back({forward1, forward2, memForward1, memForward2, wbForward1, wbForward2, stall});
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                m_v[s] = 1'b0; m_w[s] = 1'b0; m_ld[s] = 1'b0; m_rd[s] = '0;
            end
            m_counted = 1'b0; m_stalls = '0; m_haz = '0;
        end else begin
            if (act && anyh && !m_counted) m_haz = m_haz + 32'd1;
            if (f[0]) m_stalls = m_stalls + 32'd1;
            m_counted = f[0];
            for (int s = 2; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_w[s] = m_w[s-1]; m_ld[s] = m_ld[s-1]; m_rd[s] = m_rd[s-1];
            end
            m_v[0] = v && !fl && !f[0]; m_w[0] = rw; m_ld[0] = ld; m_rd[0] = rd;
        end
        sexp_q.push_back(m_stalls);
        hexp_q.push_back(m_haz);
        #1;
        sobs_q.push_back(stalls);
        hobs_q.push_back(dataHazards);
    endtask

    // Holds the instruction in decode while the model says it stalls.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic [4:0] rd, input logic rw, input logic ld);
        logic st;
        int   n = 0;
        do begin
            cyc(1'b0, 1'b1, rs, rt, ut, rd, rw, ld, 1'b0, st);
            n++;
        end while (st && n < 4);
        total++;
        if (st) begin
            bad++;
            $display("FAIL issue_bound stall still high after %0d cycles want=cleared", n);
        end
    endtask

    task automatic do_reset();
        logic st;
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, st);
    endtask

    task automatic test_reset();
        logic st;
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        cyc(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, st);
        cyc(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, st);
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL reset_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL reset_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL reset_hazards got=%0d want=%0d", ho, he); end
        end
    endtask

    task automatic test_ex_forward();
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        issue(5'd3, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL ex_fwd_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL ex_fwd_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL ex_fwd_hazards got=%0d want=%0d", ho, he); end
        end
        total++;
        if (dataHazards !== 32'd1) begin bad++; $display("FAIL ex_fwd_count got=%0d want=1", dataHazards); end
        total++;
        if (stalls !== (FWD ? 32'd0 : 32'd2)) begin
            bad++; $display("FAIL ex_fwd_stallcount got=%0d want=%0d", stalls, FWD ? 0 : 2);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        issue(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        issue(5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL load_use_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL load_use_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL load_use_hazards got=%0d want=%0d", ho, he); end
        end
        total++;
        if (stalls !== (FWD ? 32'd1 : 32'd2)) begin
            bad++; $display("FAIL load_use_stallcount got=%0d want=%0d", stalls, FWD ? 1 : 2);
        end
        total++;
        if (dataHazards !== 32'd1) begin bad++; $display("FAIL load_use_count got=%0d want=1", dataHazards); end
    endtask

    task automatic test_priority_r0();
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        issue(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        issue(5'd7, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
        issue(5'd1, 5'd5, 1'b0, 5'd12, 1'b1, 1'b0);
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL prio_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL prio_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL prio_hazards got=%0d want=%0d", ho, he); end
        end
    endtask

    task automatic test_flush();
        logic st;
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        issue(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, st);
        total++;
        if (stalls !== 32'd0) begin bad++; $display("FAIL flush_same_cycle stalls got=%0d want=0", stalls); end
        do_reset();
        issue(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, st);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, st);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, st);
        total++;
        if (dataHazards !== 32'd2) begin bad++; $display("FAIL flush_recount got=%0d want=2", dataHazards); end
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL flush_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL flush_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL flush_hazards got=%0d want=%0d", ho, he); end
        end
    endtask

    task automatic test_wrap_reset();
        logic st;
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        force dut.stalls_q = 32'hFFFF_FFFF;
        force dut.hazards_q = 32'hFFFF_FFFF;
        #1;
        release dut.stalls_q;
        release dut.hazards_q;
        m_stalls = 32'hFFFF_FFFF;
        m_haz    = 32'hFFFF_FFFF;
        issue(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, st);
        total++;
        if (stalls !== 32'd0) begin bad++; $display("FAIL wrap_stalls got=%0d want=0", stalls); end
        cyc(1'b1, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, st);
        cyc(1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, st);
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL wrap_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL wrap_stallcnt got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL wrap_hazards got=%0d want=%0d", ho, he); end
        end
    endtask

    task automatic test_back_to_back();
        logic st = 1'b0;
        logic [4:0] rs = '0, rt = '0, rd = '0;
        logic ut = 1'b0, rw = 1'b0, ld = 1'b0, v = 1'b0, fl;
        logic [6:0] fe, fo;
        logic [31:0] se, so, he, ho;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            if (!st) begin
                v  = ($urandom_range(0, 7) != 0);
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                ut = 1'($urandom_range(0, 1));
                rw = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            cyc(1'b0, v, rs, rt, ut, rd, rw, ld, fl, st);
        end
        while (fexp_q.size() != 0) begin
            fe = fexp_q.pop_front(); fo = fobs_q.pop_front();
            se = sexp_q.pop_front(); so = sobs_q.pop_front();
            he = hexp_q.pop_front(); ho = hobs_q.pop_front();
            total++; if (fo !== fe) begin bad++; $display("FAIL b2b_flags got=%b want=%b", fo, fe); end
            total++; if (so !== se) begin bad++; $display("FAIL b2b_stalls got=%0d want=%0d", so, se); end
            total++; if (ho !== he) begin bad++; $display("FAIL b2b_hazards got=%0d want=%0d", ho, he); end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 1'b0; m_w[s] = 1'b0; m_ld[s] = 1'b0; m_rd[s] = '0;
        end
        m_counted = 1'b0;
        m_stalls  = '0;
        m_haz     = '0;
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority_r0();
        test_flush();
        test_wrap_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Ports SHALL be listed as: name, direction, width, meaning; clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 idValid  in  1  decode stage holds a real instruction.
REQ-005 idRs, idRt  in  5 each  source register numbers of the decode-stage instruction.
REQ-006 idUsesRt  in  1  rt is a read operand; when 0, rt SHALL NOT be compared.
REQ-007 idRd  in  5  destination register of the decode-stage instruction.
REQ-008 idRegWrite  in  1  decode-stage instruction writes idRd.
REQ-009 idIsLoad  in  1  decode-stage instruction is a load.
REQ-010 flush  in  1  branch taken; discard the decode-stage instruction.
REQ-011 forward1, forward2  out  1 each  rs/rt take the EX-stage ALU result.
REQ-012 memForward1, memForward2  out  1 each  rs/rt take the MEM-stage result.
REQ-013 wbForward1, wbForward2  out  1 each  rs/rt take the WB-stage result.
REQ-014 stall  out  1  hold fetch/decode and insert a bubble into EX.
REQ-015 stalls, dataHazards  out  32 each  running counters.

Function
REQ-016 Tracking: 3-entry shift register (EX, MEM, WB); each entry holds {valid, rd, regWrite, isLoad}.
REQ-017 Normal cycle (stall=0, flush=0): EX<=decode fields gated by idValid; MEM<=EX; WB<=MEM.
REQ-018 Stall cycle: EX<=bubble (valid=0); MEM and WB still shift.
REQ-019 flush=1: EX<=bubble; MEM and WB still shift; flush SHALL override stall in the same cycle.
REQ-020 Match: stage matches a source when entry valid, regWrite=1, rd==source, and rd!=0; r0 SHALL never forward or stall.
REQ-021 Priority per operand: EX > MEM > WB; at most one of the three operand-1 flags high, same for operand 2.
REQ-022 Forward outputs and stall SHALL be combinational from tracker state and decode inputs (zero latency); all are forced 0 when idValid=0 or flush=1.
REQ-023 Load-use: an EX match on a load entry SHALL assert stall and SHALL NOT assert forwardN. The following cycle, the load sits in MEM and memForwardN is asserted.
REQ-024 stalls SHALL increment by 1 on every cycle with stall=1.
REQ-025 dataHazards SHALL increment once per decode instruction having any match (REQ-020), counted on its first decode cycle only.
REQ-026 An internal counted flag SHALL set when that instruction stalls and clear when it advances or is flushed.
REQ-027 Both counters SHALL wrap modulo 2^32.

Reset
REQ-028 On reset: all tracker entries valid=0; counted flag=0; stalls=0; dataHazards=0.
REQ-029 During reset: all forward outputs=0 and stall=0.
REQ-030 Reset asserted mid-stall SHALL discard the stall; the first post-reset cycle sees an empty pipeline.

Configuration
REQ-031 Macro FORWARDING_EN defined: behaviour per REQ-020..REQ-023.
REQ-032 FORWARDING_EN undefined: all six forward outputs tied 0.
REQ-033 FORWARDING_EN undefined: stall SHALL assert on any EX or MEM match (load or not); the register file writes before it reads, so a WB match needs no stall.

Structure
REQ-034 The shared package SHALL hold the stage-entry packed struct, REGISTERWIDTH, and the counters' 32-bit width constant.
REQ-035 One sub-module, hazard_compare, SHALL compare one source register against one tracker entry (REQ-020); it is instantiated 6 times.

Verification
REQ-036 add r3 in EX, decode reads rs=r3 -> forward1=1, stall=0, dataHazards +1.
REQ-037 lw r5 in EX, decode reads rt=r5 with idUsesRt=1 -> stall=1 for exactly 1 cycle, then memForward2=1; stalls=1, dataHazards=1.
REQ-038 r7 written in both EX and WB, decode reads rs=r7 -> forward1=1, wbForward1=0; a write to r0 with a read of r0 -> all flags 0.
REQ-039 Load-use stall with flush=1 in the same cycle -> stall=0, EX bubble, counted flag cleared; stalls not incremented.
REQ-040 FORWARDING_EN undefined, add r4 then a read of r4 -> stall for 2 cycles, all forward flags 0, stalls=2, dataHazards=1.
REQ-041 Counters preloaded to 32'hFFFF_FFFF, one stall cycle -> stalls=0; reset during a stall -> next cycle stall=0, counters=0.
